// File: rtl/mux_demux_router.sv
// Registered N-channel router: one debounced load latches source/destination,
// scan mode steps the source, and the selected input lands on one output slice.

module mux_demux_lane #(
  parameter int W    = 4,
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic            en,
  input  logic [SELW-1:0] dst,
  input  logic [W-1:0]    data,
  output logic [W-1:0]    q
);
  assign q = (en && dst == SELW'(IDX)) ? data : '0;
endmodule

module mux_demux_router #(
  parameter int W               = 4,
  parameter int N               = 4,
  parameter int SELW            = $clog2(N),
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_PERIOD     = 100000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  din,
  input  logic [SELW-1:0] src_sel,
  input  logic [SELW-1:0] dst_sel,
  input  logic            load,
  input  logic            enable,
  input  logic            mode,
  output logic [N*W-1:0]  dout,
  output logic [SELW-1:0] src_q,
  output logic [SELW-1:0] dst_q
);
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SPW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SPW-1:0] SP_LAST = SPW'(SCAN_PERIOD - 1);

  // Bit order in the synchronisers: {load, enable, mode}
  logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DBW-1:0]        db_cnt_q, db_cnt_d;
  logic                  load_db_q, load_db_d, load_db_dly_q, load_db_dly_d;
  logic [SPW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [SELW-1:0]       src_d, dst_d;
  logic [N-1:0][W-1:0]   dout_q, dout_d, din_a;
  logic                  load_s, enable_s, mode_s, load_pulse;
  logic [W-1:0]          src_data;

  assign load_s   = sync2_q[2];
  assign enable_s = sync2_q[1];
  assign mode_s   = sync2_q[0];
  assign din_a    = din;
  assign src_data = din_a[src_q];
  assign dout     = dout_q;

  always_comb begin
    sync1_d       = {load, enable, mode};
    sync2_d       = sync1_q;
    db_cnt_d      = db_cnt_q;
    load_db_d     = load_db_q;
    load_db_dly_d = load_db_q;
    tick_cnt_d    = tick_cnt_q;
    src_d         = src_q;
    dst_d         = dst_q;

    if (load_s == load_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      load_db_d = load_s;
      db_cnt_d  = '0;
    end else begin
      db_cnt_d = db_cnt_q + DBW'(1);
    end

    load_pulse = load_db_q & ~load_db_dly_q;

    if (!mode_s) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == SP_LAST) begin
      tick_cnt_d = '0;
      src_d      = src_q + SELW'(1);
    end else begin
      tick_cnt_d = tick_cnt_q + SPW'(1);
    end

    // A capture overrides a coincident scan step; the counter has wrapped anyway
    if (load_pulse) begin
      src_d = src_sel;
      dst_d = dst_sel;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_demux_lane #(.W(W), .SELW(SELW), .IDX(i)) u_lane (
      .en   (enable_s),
      .dst  (dst_q),
      .data (src_data),
      .q    (dout_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      db_cnt_q      <= '0;
      load_db_q     <= 1'b0;
      load_db_dly_q <= 1'b0;
      tick_cnt_q    <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      dout_q        <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_cnt_q      <= db_cnt_d;
      load_db_q     <= load_db_d;
      load_db_dly_q <= load_db_dly_d;
      tick_cnt_q    <= tick_cnt_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      dout_q        <= dout_d;
    end
  end
endmodule
